// File: rtl/pcm_fft_framer.sv
// PCM-to-FFT framer: buffers a free-running PCM strobe in a small FIFO, sends one
// FFT config byte after reset, then streams samples as FRAME_LEN-sample frames.
module pcm_fft_framer #(
  parameter int          N           = 32,
  parameter int          SW          = 16,
  parameter int          FRAME_LEN   = 1024,
  parameter int          FIFO_AW     = 4,
  parameter logic [7:0]  CONFIG_WORD = 8'h01
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [SW-1:0] pcm_data,
  input  logic          pcm_valid,
  output logic [7:0]    config_data,
  output logic          config_valid,
  input  logic          config_ready,
  output logic [N-1:0]  out_data,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready,
  output logic          overflow,
  output logic [15:0]   frame_count
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int IW    = $clog2(FRAME_LEN);
  localparam logic [FIFO_AW+1:0] DEPTH_V  = (FIFO_AW+2)'(DEPTH);
  localparam logic [IW-1:0]      LAST_IDX = IW'(FRAME_LEN - 1);

  typedef enum logic {CFG = 1'b0, STREAM = 1'b1} state_t;

  state_t             state;
  logic [SW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   fifo_cnt;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      load_idx;
  logic               full;
  logic               wr_en;
  logic               rd_en;
  logic               hs;

  // The output register is counted as a storage slot, so FIFO plus output
  // register never hold more than DEPTH samples in total.
  assign full     = ({1'b0, fifo_cnt} + (FIFO_AW+2)'(out_valid)) >= DEPTH_V;
  assign wr_en    = pcm_valid & ~full;
  assign hs       = out_valid & out_ready;
  assign rd_en    = (state == STREAM) && (fifo_cnt != '0) && (!out_valid || out_ready);
  assign load_idx = hs ? idx + 1'b1 : idx;

  // Sample storage; contents need no reset because occupancy is tracked separately.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr] <= pcm_data;
    end
  end

  // Control FSM, FIFO pointers, output register and status counters.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state        <= CFG;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      idx          <= '0;
      config_valid <= 1'b0;
      config_data  <= 8'h00;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_data     <= '0;
      overflow     <= 1'b0;
      frame_count  <= 16'h0000;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      fifo_cnt <= fifo_cnt + (FIFO_AW+1)'(wr_en) - (FIFO_AW+1)'(rd_en);
      if (pcm_valid && full) begin
        overflow <= 1'b1;
      end

      case (state)
        CFG: begin
          if (config_valid && config_ready) begin
            state        <= STREAM;
            config_valid <= 1'b0;
          end else begin
            config_valid <= 1'b1;
            config_data  <= CONFIG_WORD;
          end
        end
        STREAM: begin
          config_valid <= 1'b0;
        end
        default: begin
          state <= CFG;
        end
      endcase

      if (hs) begin
        idx <= idx + 1'b1;
        if (out_last) begin
          frame_count <= frame_count + 16'd1;
        end
      end

      // The index of a newly loaded sample already accounts for a same-cycle handshake.
      if (rd_en) begin
        out_valid <= 1'b1;
        out_data  <= N'(mem[rd_ptr]);
        out_last  <= (load_idx == LAST_IDX);
      end else if (hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcm_fft_framer.sv
// Scoreboard bench for pcm_fft_framer with FRAME_LEN=8, FIFO depth 16.
module tb_pcm_fft_framer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [15:0] pcm_data;
  logic        pcm_valid;
  logic [7:0]  config_data;
  logic        config_valid;
  logic        config_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        overflow;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;
  int sent_idx = 0;
  logic [32:0] exp_q[$];

  pcm_fft_framer #(.N(32), .SW(16), .FRAME_LEN(8), .FIFO_AW(4), .CONFIG_WORD(8'h01)) dut (
    .aclk(aclk), .aresetn(aresetn), .pcm_data(pcm_data), .pcm_valid(pcm_valid),
    .config_data(config_data), .config_valid(config_valid), .config_ready(config_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .overflow(overflow), .frame_count(frame_count)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Drive one PCM strobe; retained samples get an expected entry with their frame position.
  task automatic send(input logic [15:0] d, input bit keep);
    pcm_valid = 1'b1;
    pcm_data  = d;
    if (keep) begin
      exp_q.push_back({(sent_idx == 7), 16'h0000, d});
      sent_idx = (sent_idx + 1) % 8;
    end
    tick();
    pcm_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 300) begin
      tick();
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_config_valid"}, 32'(config_valid), 32'd0);
    check({tag, "_config_data"},  32'(config_data),  32'd0);
    check({tag, "_out_valid"},    32'(out_valid),    32'd0);
    check({tag, "_out_last"},     32'(out_last),     32'd0);
    check({tag, "_out_data"},     out_data,          32'd0);
    check({tag, "_overflow"},     32'(overflow),     32'd0);
    check({tag, "_frame_count"},  32'(frame_count),  32'd0);
  endtask

  // Monitor: pops on every handshake and checks stability across stalls.
  logic        stalled = 1'b0;
  logic [31:0] held_data;
  logic        held_last;
  always @(negedge aclk) begin
    if (aresetn === 1'b1 && stalled) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
        errors++;
        $display("FAIL stall_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                 out_valid, out_data, out_last, held_data, held_last);
      end
    end
    if (aresetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      logic [32:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got d=%h l=%b expected no beat", out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e[31:0] || out_last !== e[32]) begin
          errors++;
          $display("FAIL beat: got d=%h l=%b expected d=%h l=%b", out_data, out_last, e[31:0], e[32]);
        end
      end
    end
    stalled   = (aresetn === 1'b1) && (out_valid === 1'b1) && (out_ready !== 1'b1);
    held_data = out_data;
    held_last = out_last;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; pcm_valid = 1'b0; pcm_data = 16'h0000;
    config_ready = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");

    // Config handshake stalled for 5 cycles.
    aresetn = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("cfg_valid_hold", 32'(config_valid), 32'd1);
      check("cfg_data_hold", 32'(config_data), 32'h01);
      check("cfg_out_valid", 32'(out_valid), 32'd0);
      tick();
    end
    config_ready = 1'b1;
    check("cfg_valid_hs", 32'(config_valid), 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("cfg_valid_after", 32'(config_valid), 32'd0);
      tick();
    end

    // Back-to-back frames and first-beat latency.
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      send(16'(i), 1'b1);
      pcm_valid = 1'b1;
      if (i == 1) check("latency_k1", 32'(out_valid), 32'd0);
      if (i == 2) check("latency_k2", 32'(out_valid), 32'd1);
    end
    pcm_valid = 1'b0;
    drain();
    check("b2b_frame_count", 32'(frame_count), 32'd2);

    // Backpressure: ready toggles each cycle, sample every other cycle.
    for (int c = 0; c < 48; c++) begin
      out_ready = (c % 2 == 0);
      if (c % 2 == 0) send(16'(16'h0200 + c / 2), 1'b1);
      else tick();
    end
    drain();
    check("bp_overflow", 32'(overflow), 32'd0);
    check("bp_frame_count", 32'(frame_count), 32'd5);

    // Overflow: 20 samples with no ready, 16 retained.
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send(16'(16'h0300 + i), (i < 16));
      if (i == 15) check("ovf_before", 32'(overflow), 32'd0);
      if (i == 16) check("ovf_at_17", 32'(overflow), 32'd1);
    end
    drain();
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_frame_count", 32'(frame_count), 32'd7);

    // Negative samples: no sign extension into the imaginary half.
    send(16'h8000, 1'b1);
    send(16'hFFFF, 1'b1);
    drain();

    // Complete the current frame, then reset after sample 5 of the next.
    for (int i = 0; i < 6; i++) send(16'(16'h0400 + i), 1'b1);
    drain();
    check("pre_reset_frame_count", 32'(frame_count), 32'd8);
    for (int i = 0; i < 5; i++) send(16'(16'h0500 + i), 1'b1);
    drain();
    aresetn = 1'b0;
    tick();
    check_reset_outputs("midreset");
    exp_q.delete();
    sent_idx = 0;
    aresetn = 1'b1;
    tick();
    check("rst_cfg_valid", 32'(config_valid), 32'd1);
    check("rst_cfg_data", 32'(config_data), 32'h01);
    config_ready = 1'b1;
    tick();
    config_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'(16'h0600 + i), 1'b1);
    drain();
    check("rst_frame_count", 32'(frame_count), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
